// File: rtl/mc_ctrl.sv
// Multicycle MIPS main controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing, with outputs decoded combinationally from state.
// Each instruction takes 2-5 cycles. A mem_ready=0 stall in FETCH, MEMRD or MEMWR holds the state for one cycle.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t cur;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:   if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_RTYP:      cur <= S_EXECUTE;
                        OP_BEQ:       cur <= S_BRANCH;
                        OP_ADDI:      cur <= S_ADDIEX;
                        OP_J:         cur <= S_JUMP;
                        default:      cur <= S_FETCH;
                    endcase
                end
                S_MEMADR:  cur <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) cur <= S_MEMWB;
                S_MEMWR:   if (mem_ready) cur <= S_FETCH;
                S_EXECUTE: cur <= S_ALUWB;
                S_ADDIEX:  cur <= S_ADDIWB;
                default:   cur <= S_FETCH;   // writeback/branch/jump and unused codes 12-15
            endcase
        end
    end

    always_comb begin
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        illegal  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        case (cur)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        pcen = pcwrite | (branch & zero);
        // Reset kills every strobe immediately so an aborted instruction leaves no partial write.
        if (!rst_n) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: instruction-level model (state list per opcode plus per-state control table) under directed and random stalls.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    int    ncmp = 0;
    int    nfail = 0;
    ctrl_t tab [0:11];

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal), .state(state)
    );

    function automatic ctrl_t actual();
        return '{pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                 alusrcb, pcsrc, aluop, illegal};
    endfunction

    function automatic bit legal(input logic [5:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == ADDI) || (o == JMP);
    endfunction

    task automatic check_cycle(input int s, input bit rdy, input bit z, input logic [5:0] o, input string tag);
        ctrl_t e;
        ctrl_t a;
        e = tab[s];
        if (s == 0) begin e.irwrite = rdy; e.pcen = rdy; end
        if (s == 8) e.pcen = z;
        if (s == 1) e.illegal = !legal(o);
        a = actual();
        ncmp++;
        assert (state === 4'(s)) else begin
            nfail++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state, s);
        end
        ncmp++;
        assert (a === e) else begin
            nfail++;
            $error("FAIL %s ctrl (state %0d) observed=%b expected=%b", tag, s, a, e);
        end
    endtask

    // Runs one instruction from FETCH; stalls st_n cycles the first time st_state is visited.
    task automatic run_instr(input logic [5:0] o, input int st_state, input int st_n,
                             input bit rnd, input bit z, input string tag);
        int q[$];
        int left;
        int s;
        bit rdy;
        bit zz;
        left = st_n;
        case (o)
            LW:      q = '{0, 1, 2, 3, 4};
            SW:      q = '{0, 1, 2, 5};
            RT:      q = '{0, 1, 6, 7};
            ADDI:    q = '{0, 1, 9, 10};
            BEQ:     q = '{0, 1, 8};
            JMP:     q = '{0, 1, 11};
            default: q = '{0, 1};
        endcase
        op = o;
        while (q.size() > 0) begin
            s = q[0];
            if (s == st_state && left > 0) begin
                rdy = 1'b0;
                left--;
            end else begin
                rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            zz = rnd ? 1'($urandom_range(0, 1)) : z;
            mem_ready = rdy;
            zero = zz;
            @(negedge clk);
            check_cycle(s, rdy, zz, o, tag);
            @(posedge clk);
            #1;
            if (!((s == 0 || s == 3 || s == 5) && !rdy)) void'(q.pop_front());
        end
    endtask

    initial begin
        logic [5:0] pick [0:6];
        logic [5:0] ro;
        ctrl_t      rexp;
        tab[0]  = ctrl_t'({8'b0000_0000, 2'b01, 2'b00, 2'b00, 1'b0});
        tab[1]  = ctrl_t'({8'b0000_0000, 2'b11, 2'b00, 2'b00, 1'b0});
        tab[2]  = ctrl_t'({8'b0000_0001, 2'b10, 2'b00, 2'b00, 1'b0});
        tab[3]  = ctrl_t'({8'b0000_1000, 2'b00, 2'b00, 2'b00, 1'b0});
        tab[4]  = ctrl_t'({8'b0001_0100, 2'b00, 2'b00, 2'b00, 1'b0});
        tab[5]  = ctrl_t'({8'b0100_1000, 2'b00, 2'b00, 2'b00, 1'b0});
        tab[6]  = ctrl_t'({8'b0000_0001, 2'b00, 2'b00, 2'b10, 1'b0});
        tab[7]  = ctrl_t'({8'b0001_0010, 2'b00, 2'b00, 2'b00, 1'b0});
        tab[8]  = ctrl_t'({8'b0000_0001, 2'b00, 2'b01, 2'b01, 1'b0});
        tab[9]  = ctrl_t'({8'b0000_0001, 2'b10, 2'b00, 2'b00, 1'b0});
        tab[10] = ctrl_t'({8'b0001_0000, 2'b00, 2'b00, 2'b00, 1'b0});
        tab[11] = ctrl_t'({8'b1000_0000, 2'b00, 2'b10, 2'b00, 1'b0});
        pick = '{LW, SW, RT, BEQ, ADDI, JMP, 6'b111111};

        // In reset with mem_ready high: FETCH selects, no strobes.
        #2;
        ncmp++;
        assert (state === 4'd0) else begin
            nfail++;
            $error("FAIL reset_state observed=%0d expected=0", state);
        end
        ncmp++;
        assert (actual() === tab[0]) else begin
            nfail++;
            $error("FAIL reset_ctrl observed=%b expected=%b", actual(), tab[0]);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr(RT,   -1, 0, 1'b0, 1'b0, "rtype");
        run_instr(LW,    3, 2, 1'b0, 1'b0, "lw_memrd_stall");
        run_instr(SW,    0, 1, 1'b0, 1'b0, "sw_fetch_stall");
        run_instr(BEQ,  -1, 0, 1'b0, 1'b1, "beq_taken");
        run_instr(BEQ,  -1, 0, 1'b0, 1'b0, "beq_not_taken");
        run_instr(JMP,  -1, 0, 1'b0, 1'b0, "jump");
        run_instr(ADDI, -1, 0, 1'b0, 1'b0, "addi");
        run_instr(6'b111111, -1, 0, 1'b0, 1'b0, "illegal");
        run_instr(SW,    5, 3, 1'b0, 1'b0, "sw_memwr_stall");

        // Abort an sw while stalled in MEMWR.
        op = SW;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check_cycle(5, 1'b0, zero, SW, "pre_abort");
        #2 rst_n = 1'b0;
        #1;
        rexp = tab[0];
        ncmp++;
        assert (state === 4'd0) else begin
            nfail++;
            $error("FAIL abort_state observed=%0d expected=0", state);
        end
        ncmp++;
        assert (actual() === rexp) else begin
            nfail++;
            $error("FAIL abort_ctrl observed=%b expected=%b", actual(), rexp);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 80; i++) begin
            ro = pick[$urandom_range(0, 6)];
            if (ro == 6'b111111) ro = 6'($urandom_range(0, 63));
            run_instr(ro, -1, 0, 1'b1, 1'b0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
